energy_threshold_gen: RTL



---
 rtl/energy_threshold_gen.sv | 116 +++++++++++
 1 files changed

// File: rtl/energy_threshold_gen.sv
// Windowed sum-of-squares energy with a noise threshold learned over the first calibration windows.
// Optional ADAPT_TH_EN: after calibration, TH tracks quiet windows as an exponential average.
module energy_threshold_gen #(
  parameter int SAMPLE_W    = 16,
  parameter int LOG2_WIN    = 10,
  parameter int LOG2_INIT   = 3,
  parameter int ALPHA_SHIFT = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] sampleIn,
  input  logic                       sampleValid,
  input  logic                       eventDetected,
  output logic [63:0]                energy,
  output logic                       energyValid,
  output logic [63:0]                TH,
  output logic                       initDone
);

  if ((2*SAMPLE_W + LOG2_WIN + LOG2_INIT > 64) || (ALPHA_SHIFT >= 64)) begin : g_badConfig
    $error("energy_threshold_gen: accumulators would not fit in 64 bits");
  end

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                       r_state;
  state_t                       w_nextState;
  logic [LOG2_WIN-1:0]          r_sampleCnt;
  logic [LOG2_INIT-1:0]         r_winCnt;
  logic [63:0]                  r_acc;
  logic [63:0]                  r_initAcc;

  logic signed [2*SAMPLE_W-1:0] w_sampleExt;
  logic signed [2*SAMPLE_W-1:0] w_prod;
  logic [63:0]                  w_square;
  logic [63:0]                  w_newEnergy;
  logic [63:0]                  w_initSum;
  logic [63:0]                  w_thInit;
  logic [63:0]                  w_thNext;
  logic                         w_windowEnd;
  logic                         w_lastInit;

  // Sign-extend before multiplying so the most negative sample squares to a positive value.
  assign w_sampleExt = {{SAMPLE_W{sampleIn[SAMPLE_W-1]}}, sampleIn};
  assign w_prod      = w_sampleExt * w_sampleExt;
  assign w_square    = 64'($unsigned(w_prod));
  assign w_newEnergy = r_acc + w_square;
  assign w_initSum   = r_initAcc + w_newEnergy;
  assign w_thInit    = w_initSum >> LOG2_INIT;
  assign w_windowEnd = sampleValid && (r_sampleCnt == '1);
  assign w_lastInit  = (r_winCnt == '1);

`ifdef ADAPT_TH_EN
  logic [63:0] w_thAdapt;
  assign w_thAdapt = TH - (TH >> ALPHA_SHIFT) + (w_newEnergy >> ALPHA_SHIFT);
`else
  logic w_unusedEvent;
  assign w_unusedEvent = eventDetected;
`endif

  always_comb begin
    w_nextState = r_state;
    w_thNext    = TH;
    if (w_windowEnd) begin
      if (r_state == ST_INIT) begin
        if (w_lastInit) begin
          w_nextState = ST_RUN;
          w_thNext    = (w_thInit == 64'd0) ? 64'd1 : w_thInit;
        end
      end
`ifdef ADAPT_TH_EN
      else if (!eventDetected) begin
        w_thNext = (w_thAdapt == 64'd0) ? 64'd1 : w_thAdapt;
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_INIT;
    else       r_state <= w_nextState;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sampleCnt <= '0;
      r_winCnt    <= '0;
      r_acc       <= '0;
      r_initAcc   <= '0;
      energy      <= '0;
      energyValid <= 1'b0;
      TH          <= '0;
      initDone    <= 1'b0;
    end else begin
      energyValid <= 1'b0;
      TH          <= w_thNext;
      initDone    <= (w_nextState == ST_RUN);
      if (sampleValid) begin
        if (w_windowEnd) begin
          energy      <= w_newEnergy;
          energyValid <= 1'b1;
          r_acc       <= '0;
          r_sampleCnt <= '0;
          if (r_state == ST_INIT) begin
            r_initAcc <= w_lastInit ? 64'd0 : w_initSum;
            r_winCnt  <= r_winCnt + 1'b1;
          end
        end else begin
          r_acc       <= w_newEnergy;
          r_sampleCnt <= r_sampleCnt + 1'b1;
        end
      end
    end
  end

endmodule
